// File: rtl/prog_mem_arbiter.sv
// Arbitrates the single program-memory port between the fetch unit and the boot/debug loader.
// Grants are combinational; every accepted access is registered and drives memory for exactly one cycle.
module prog_mem_arbiter #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  load_req,
  input  logic                  load_we,
  input  logic                  load_lock,
  input  logic [DATA_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_gnt,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  align_err,
  output logic                  range_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [DATA_WIDTH-1:0] ADDR_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

  typedef enum logic [1:0] {IDLE, ACC_F, ACC_L} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        wait_cnt;
  logic [DATA_WIDTH-1:2]   acc_addr;
  logic                    acc_we;
  logic                    acc_in_range;
  logic [DATA_WIDTH-1:0]   acc_wdata;

  logic                    starved_c;
  logic [DATA_WIDTH-1:0]   gnt_addr_c;
  logic                    gnt_in_range_c;

  // wait_cnt + 1 > limit is wait_cnt >= limit, written so a zero limit is not a constant compare
  assign starved_c      = load_req && ((32'(wait_cnt) + 32'd1) > STARVE_LIMIT);
  assign gnt_addr_c     = fetch_gnt ? fetch_addr : load_addr;
  assign gnt_in_range_c = gnt_addr_c < ADDR_LIMIT;

  // Lock beats starvation beats fetch priority; at most one grant per cycle
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (load_lock) begin
      load_gnt = load_req;
    end else if (starved_c) begin
      load_gnt = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt = 1'b1;
    end else begin
      load_gnt = load_req;
    end
  end

  // Memory sees only the registered access; state clears asynchronously so a partial write never commits
  assign mem_addr  = (state == IDLE) ? '0 : {acc_addr, 2'b00};
  assign mem_we    = (state == ACC_L) && acc_we && acc_in_range;
  assign mem_wdata = acc_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      acc_addr     <= '0;
      acc_we       <= 1'b0;
      acc_in_range <= 1'b0;
      acc_wdata    <= '0;
      fetch_valid  <= 1'b0;
      fetch_data   <= '0;
      load_valid   <= 1'b0;
      load_rdata   <= '0;
      align_err    <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      if (load_req && !load_gnt) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (fetch_gnt) begin
        state <= ACC_F;
      end else if (load_gnt) begin
        state <= ACC_L;
      end else begin
        state <= IDLE;
      end

      if (fetch_gnt || load_gnt) begin
        acc_addr     <= gnt_addr_c[DATA_WIDTH-1:2];
        acc_we       <= load_gnt && load_we;
        acc_in_range <= gnt_in_range_c;
        acc_wdata    <= load_wdata;
        align_err    <= align_err || (gnt_addr_c[1:0] != 2'b00);
        range_err    <= range_err || !gnt_in_range_c;
      end

      // Completion: out-of-range reads and all writes return zero
      fetch_valid <= (state == ACC_F);
      load_valid  <= (state == ACC_L);
      if (state == ACC_F) begin
        fetch_data <= acc_in_range ? mem_rdata : '0;
      end
      if (state == ACC_L) begin
        load_rdata <= (acc_in_range && !acc_we) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Randomized and directed bench for prog_mem_arbiter: an in-order reference model of program memory
// feeds a scoreboard that a negedge monitor checks against grants, memory drive and completions.
module tb_prog_mem_arbiter;

  localparam int DEPTH  = 256;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0, load_req = 1'b0, load_we = 1'b0, load_lock = 1'b0;
  logic [31:0] fetch_addr = '0, load_addr = '0, load_wdata = '0;
  logic        fetch_gnt, fetch_valid, load_gnt, load_valid, mem_we, align_err, range_err;
  logic [31:0] fetch_data, load_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance with strict loader priority
  logic        s_fetch_req = 1'b0, s_load_req = 1'b0;
  logic        s_fetch_gnt, s_fetch_valid, s_load_gnt, s_load_valid, s_mem_we, s_align_err, s_range_err;
  logic [31:0] s_fetch_data, s_load_rdata, s_mem_addr, s_mem_wdata;
  logic [31:0] s_zero = '0;
  logic        s_zero1 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prog_mem_arbiter #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .STARVE_LIMIT(STARVE)) u_dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .load_req(load_req), .load_we(load_we), .load_lock(load_lock),
    .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
    .load_valid(load_valid), .load_rdata(load_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .align_err(align_err), .range_err(range_err)
  );

  prog_mem_arbiter #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .STARVE_LIMIT(0)) u_s0 (
    .clk(clk), .reset(reset),
    .fetch_req(s_fetch_req), .fetch_addr(s_zero), .fetch_gnt(s_fetch_gnt),
    .fetch_valid(s_fetch_valid), .fetch_data(s_fetch_data),
    .load_req(s_load_req), .load_we(s_zero1), .load_lock(s_zero1),
    .load_addr(s_zero), .load_wdata(s_zero), .load_gnt(s_load_gnt),
    .load_valid(s_load_valid), .load_rdata(s_load_rdata),
    .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(s_zero),
    .align_err(s_align_err), .range_err(s_range_err)
  );

  // Environment memory: words past the real depth hold junk the DUT must never return
  logic [31:0] emem [0:1023];
  logic [31:0] ref_mem [0:255];
  assign mem_rdata = emem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) emem[mem_addr[11:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard state
  typedef struct packed { logic [31:0] due; logic [31:0] data; } exp_t;
  exp_t        fq[$];
  exp_t        lq[$];
  int          cyc = 0;
  int          wait_m = 0;
  int          lv_count = 0;
  bit          exp_align = 0, exp_range = 0;
  bit          st_v = 0, st_load = 0, st_we = 0;
  logic [31:0] st_addr = '0, st_wdata = '0;

  always @(negedge clk) begin
    bit          el, ef, in_rng;
    logic [31:0] rd;
    cyc++;
    if (!reset) begin
      check("rst_fetch_valid", 32'(fetch_valid), 0);
      check("rst_load_valid", 32'(load_valid), 0);
      check("rst_align_err", 32'(align_err), 0);
      check("rst_range_err", 32'(range_err), 0);
      check("rst_fetch_data", fetch_data, 0);
      check("rst_load_rdata", load_rdata, 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", mem_addr, 0);
      st_v = 0; fq.delete(); lq.delete();
      wait_m = 0; exp_align = 0; exp_range = 0;
    end else begin
      if (fq.size() > 0 && fq[0].due == 32'(cyc)) begin
        check("fetch_valid", 32'(fetch_valid), 1);
        check("fetch_data", fetch_data, fq[0].data);
        void'(fq.pop_front());
      end else begin
        check("fetch_valid_idle", 32'(fetch_valid), 0);
      end
      if (lq.size() > 0 && lq[0].due == 32'(cyc)) begin
        check("load_valid", 32'(load_valid), 1);
        check("load_rdata", load_rdata, lq[0].data);
        void'(lq.pop_front());
      end else begin
        check("load_valid_idle", 32'(load_valid), 0);
      end
      if (load_valid) lv_count++;

      // Access accepted at the previous edge is the one on the memory port now
      if (st_v) begin
        in_rng = st_addr < 32'(DEPTH * 4);
        check("mem_addr", mem_addr, {st_addr[31:2], 2'b00});
        check("mem_we", 32'(mem_we), 32'(st_load && st_we && in_rng));
        if (st_load && st_we) check("mem_wdata", mem_wdata, st_wdata);
        exp_align = exp_align || (st_addr[1:0] != 2'b00);
        exp_range = exp_range || !in_rng;
        rd = in_rng ? ref_mem[st_addr[9:2]] : 32'h0;
        if (st_load && st_we && in_rng) ref_mem[st_addr[9:2]] = st_wdata;
        if (st_load) lq.push_back(exp_t'({32'(cyc + 1), st_we ? 32'h0 : rd}));
        else         fq.push_back(exp_t'({32'(cyc + 1), rd}));
      end else begin
        check("mem_we_idle", 32'(mem_we), 0);
        check("mem_addr_idle", mem_addr, 0);
      end
      check("align_err", 32'(align_err), 32'(exp_align));
      check("range_err", 32'(range_err), 32'(exp_range));

      if (load_lock) begin el = load_req; ef = 0; end
      else if (load_req && wait_m >= STARVE) begin el = 1; ef = 0; end
      else if (fetch_req) begin el = 0; ef = 1; end
      else begin el = load_req; ef = 0; end
      check("load_gnt", 32'(load_gnt), 32'(el));
      check("fetch_gnt", 32'(fetch_gnt), 32'(ef));

      st_v = el || ef; st_load = el; st_we = load_we;
      st_addr = el ? load_addr : fetch_addr; st_wdata = load_wdata;
      wait_m = (load_req && !el) ? ((wait_m < 255) ? wait_m + 1 : 255) : 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 88) return 32'($urandom_range(0, 15)) << 2;
    if (r < 95) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
    return (32'($urandom_range(256, 299)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int k;
    int lv0;
    bit fg, lg;
    for (int i = 0; i < 1024; i++) begin
      emem[i] = (i < 256) ? $urandom() : (32'hBAD0_0000 | 32'(i));
      if (i < 256) ref_mem[i] = emem[i];
    end
    emem[0] = 32'h2008_0005; emem[1] = 32'h2009_0007; emem[2] = 32'h0109_5020;
    for (int i = 0; i < 3; i++) ref_mem[i] = emem[i];

    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Back-to-back fetches of the preloaded program
    fetch_req = 1; fetch_addr = 32'h0; step();
    fetch_addr = 32'h4; step();
    fetch_addr = 32'h8; step();
    fetch_req = 0; repeat (3) step();

    // Starved loader overrides a continuously requesting fetch
    fetch_req = 1; fetch_addr = 32'h0;
    load_req = 1; load_we = 1; load_addr = 32'h10; load_wdata = 32'hDEAD_BEEF;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (load_gnt) k = i;
    end
    check("starve_gnt_cycle", 32'(k), 32'd5);
    @(posedge clk); #1 load_req = 0; fetch_addr = 32'h10;
    step(); fetch_req = 0; repeat (3) step();

    // Locked loader burst; fetch resumes as soon as the lock drops
    lv0 = lv_count;
    load_lock = 1; fetch_req = 1; fetch_addr = 32'h4; load_req = 1; load_we = 1;
    for (int i = 0; i < 4; i++) begin
      load_addr = 32'(i * 4); load_wdata = $urandom(); step();
    end
    load_req = 0; step();
    load_lock = 0;
    #1 check("lock_release_fgnt", 32'(fetch_gnt), 1);
    step(); fetch_req = 0; repeat (3) step();
    check("lock_burst_valids", 32'(lv_count - lv0), 32'd4);

    // Out-of-range write, then misaligned out-of-range fetch
    load_req = 1; load_we = 1; load_addr = 32'h400; load_wdata = 32'h1234_5678; step();
    load_req = 0; fetch_req = 1; fetch_addr = 32'h401; step();
    fetch_req = 0; repeat (3) step();
    check("range_err_sticky", 32'(range_err), 1);
    check("align_err_set", 32'(align_err), 1);

    // Reset landing in the ACC_L cycle of a write
    do_reset();
    load_req = 1; load_we = 1; load_addr = 32'h20; load_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1 load_req = 0;
    check("accl_mem_we", 32'(mem_we), 1);
    #2 reset = 1'b0;
    #1 check("rst_async_mem_we", 32'(mem_we), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    step();
    fetch_req = 1; fetch_addr = 32'h20; step();
    fetch_req = 0; repeat (3) step();

    // Strict loader priority when the starvation limit is zero
    s_fetch_req = 1; s_load_req = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("s0_load_gnt", 32'(s_load_gnt), 1);
      check("s0_fetch_gnt", 32'(s_fetch_gnt), 0);
    end
    @(posedge clk); #1 s_load_req = 0;
    @(negedge clk);
    check("s0_fetch_after_drop", 32'(s_fetch_gnt), 1);
    step(); s_fetch_req = 0;

    // Randomized traffic honouring the hold-until-granted handshake
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); fg = fetch_gnt; lg = load_gnt;
      @(posedge clk); #1;
      if (fg || !fetch_req || $urandom_range(0, 15) == 0) begin
        fetch_req = ($urandom_range(0, 3) != 0); fetch_addr = rand_addr();
      end
      if (lg || !load_req || $urandom_range(0, 15) == 0) begin
        load_req = ($urandom_range(0, 2) == 0); load_we = 1'($urandom_range(0, 1));
        load_addr = rand_addr(); load_wdata = $urandom();
      end
      if ($urandom_range(0, 31) == 0) load_lock = !load_lock;
    end
    fetch_req = 0; load_req = 0; load_lock = 0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
